pipelined_subtractor_48bit: RTL

//   Two-stage pipelined 48-bit subtractor computing Diff = A - B - Bin with borrow out.
//   It is the inverse-direction partner of the 48-bit carry-lookahead adder in the

---
 rtl/pipelined_subtractor_48bit_pkg.sv | 21 ++
 rtl/cla_sub_slice.sv | 51 +++++
 rtl/pipelined_subtractor_48bit.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipelined_subtractor_48bit_pkg.sv
// Shared widths, stage-1 register layout and helpers for the 48-bit pipelined subtractor.
// Slice split is 32 (lower, stage 1) + 16 (upper, stage 2).
package pipelined_subtractor_48bit_pkg;

  localparam int SUB_WIDTH = 48;
  localparam int SUB_LO_W  = 32;
  localparam int SUB_HI_W  = SUB_WIDTH - SUB_LO_W;

  // Everything stage 2 needs: finished lower half, its borrow, raw upper operands.
  typedef struct packed {
    logic [SUB_LO_W-1:0] lo;
    logic                b;
    logic [SUB_HI_W-1:0] ahi;
    logic [SUB_HI_W-1:0] bhi;
  } s1_t;

  function automatic logic [SUB_WIDTH-1:0] negate48(input logic [SUB_WIDTH-1:0] x);
    return ~x + SUB_WIDTH'(1);
  endfunction

endpackage

// File: rtl/cla_sub_slice.sv
// Combinational carry-lookahead subtract slice: D = X - Y - bin, bout = borrow.
// Computed as X + ~Y + ~bin with a Kogge-Stone prefix carry network.
module cla_sub_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic         bin,
  output logic [W-1:0] D,
  output logic         bout
);

  logic         cin;
  logic [W-1:0] prop;
  logic [W-1:0] gg;
  logic [W-1:0] pp;
  logic [W-1:0] gn;
  logic [W-1:0] pn;
  logic [W:0]   carry;

  assign cin = ~bin;

  always_comb begin
    prop  = X ^ ~Y;
    gg    = X & ~Y;
    pp    = prop;
    gn    = '0;
    pn    = '0;
    // Fold the carry-in into bit 0 so each prefix gg[i] is the carry out of bit i.
    gg[0] = gg[0] | (pp[0] & cin);
    for (int l = 0; (1 << l) < W; l++) begin
      gn = gg;
      pn = pp;
      for (int i = (1 << l); i < W; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pn[i] = pp[i] & pp[i - (1 << l)];
      end
      gg = gn;
      pp = pn;
    end
  end

  assign carry = {gg, cin};

  for (genvar gi = 0; gi < W; gi++) begin : g_sum
    assign D[gi] = prop[gi] ^ carry[gi];
  end

  assign bout = ~carry[W];

endmodule

// File: rtl/pipelined_subtractor_48bit.sv
// Two-stage 48-bit subtractor with valid/ready on both ends; registered borrow between slices.
// Build option ABS_DIFF_EN: output |A-B-Bin| and add a Neg port equal to Bout.
module pipelined_subtractor_48bit
  import pipelined_subtractor_48bit_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH,
  parameter int LO_W  = SUB_LO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef ABS_DIFF_EN
  ,
  output logic             Neg
`endif
);

  localparam int HI_W = WIDTH - LO_W;

  s1_t              s1_reg;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             out_valid_reg;

  logic             s2_en;
  logic             s1_en;
  logic             accept;
  logic [LO_W-1:0]  lo_d;
  logic             lo_bout;
  logic [HI_W-1:0]  hi_d;
  logic             hi_bout;
  logic [WIDTH-1:0] raw_diff;
  logic [WIDTH-1:0] diff_next;

  assign s2_en    = !out_valid_reg || out_ready;
  assign s1_en    = !s1_valid_reg || s2_en;
  assign in_ready = s1_en && !rst;
  assign accept   = in_valid && in_ready;

  cla_sub_slice #(.W(LO_W)) u_lo (
    .X    (A[LO_W-1:0]),
    .Y    (B[LO_W-1:0]),
    .bin  (Bin),
    .D    (lo_d),
    .bout (lo_bout)
  );

  cla_sub_slice #(.W(HI_W)) u_hi (
    .X    (s1_reg.ahi),
    .Y    (s1_reg.bhi),
    .bin  (s1_reg.b),
    .D    (hi_d),
    .bout (hi_bout)
  );

  assign raw_diff = {hi_d, s1_reg.lo};

`ifdef ABS_DIFF_EN
  assign diff_next = hi_bout ? negate48(raw_diff) : raw_diff;
`else
  assign diff_next = raw_diff;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg        <= '0;
      s1_valid_reg  <= 1'b0;
      diff_reg      <= '0;
      bout_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      // Stage 1 refills whenever it is empty or stage 2 is draining it this cycle.
      if (s1_en) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_reg <= '{lo: lo_d, b: lo_bout, ahi: A[WIDTH-1:LO_W], bhi: B[WIDTH-1:LO_W]};
        end
      end
      if (s2_en) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          diff_reg <= diff_next;
          bout_reg <= hi_bout;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign Diff      = diff_reg;
  assign Bout      = bout_reg;
`ifdef ABS_DIFF_EN
  assign Neg       = bout_reg;
`endif

endmodule
